// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl
//  Purpose  : Control FSM for a multi-cycle RV32I-style datapath. It sequences
//             FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and produces the
//             datapath strobes. An unrecognised opcode traps until reset.
//  Ports    : clk, reset (async, active-high)
//             instruction[31:0], imem_ready, dmem_ready, branch_taken (in)
//             imem_req, ir_write, alu_src_a, alu_src_b, dmem_req, dmem_we,
//             reg_write, wb_sel[1:0], pc_write, pc_src[1:0],
//             state[2:0], illegal, instr_count[COUNT_W-1:0] (out)
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        instruction,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    input  logic               branch_taken,
    output logic               imem_req,
    output logic               ir_write,
    output logic               alu_src_a,
    output logic               alu_src_b,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic               reg_write,
    output logic [1:0]         wb_sel,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic [2:0]         state,
    output logic               illegal,
    output logic [COUNT_W-1:0] instr_count
);

    // State encoding
    localparam logic [2:0] c_FETCH  = 3'd0;
    localparam logic [2:0] c_DECODE = 3'd1;
    localparam logic [2:0] c_EXEC   = 3'd2;
    localparam logic [2:0] c_MEM    = 3'd3;
    localparam logic [2:0] c_WB     = 3'd4;
    localparam logic [2:0] c_TRAP   = 3'd5;

    // Opcodes
    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_I     = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;

    localparam logic [COUNT_W-1:0] c_COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    logic [2:0]         r_state;
    logic [6:0]         r_opcode;
    logic [4:0]         r_rd;
    logic               r_illegal;
    logic [COUNT_W-1:0] r_count;

    logic w_is_r, w_is_i, w_is_load, w_is_store, w_is_branch;
    logic w_is_jal, w_is_jalr, w_is_lui, w_is_auipc, w_legal;
    logic w_unused_instr;

    // Only opcode and rd are needed by the controller; the rest of the word
    // belongs to the datapath.
    assign w_unused_instr = ^instruction[31:12];

    // Instruction class, decoded from the latched opcode only so that no
    // output ever depends combinationally on the instruction bus.
    assign w_is_r      = (r_opcode == c_OP_R);
    assign w_is_i      = (r_opcode == c_OP_I);
    assign w_is_load   = (r_opcode == c_OP_LOAD);
    assign w_is_store  = (r_opcode == c_OP_STORE);
    assign w_is_branch = (r_opcode == c_OP_BR);
    assign w_is_jal    = (r_opcode == c_OP_JAL);
    assign w_is_jalr   = (r_opcode == c_OP_JALR);
    assign w_is_lui    = (r_opcode == c_OP_LUI);
    assign w_is_auipc  = (r_opcode == c_OP_AUIPC);
    assign w_legal     = w_is_r | w_is_i | w_is_load | w_is_store | w_is_branch |
                         w_is_jal | w_is_jalr | w_is_lui | w_is_auipc;

    // ------------------------------------------------------------------
    // Sequencing, operand latch and retirement counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_FETCH;
            r_opcode  <= 7'd0;
            r_rd      <= 5'd0;
            r_illegal <= 1'b0;
            r_count   <= '0;
        end else begin
            case (r_state)
                c_FETCH: begin
                    if (imem_ready) begin
                        r_opcode <= instruction[6:0];
                        r_rd     <= instruction[11:7];
                        r_state  <= c_DECODE;
                    end
                end
                c_DECODE: begin
                    if (w_legal) begin
                        r_state <= c_EXEC;
                    end else begin
                        r_state   <= c_TRAP;
                        r_illegal <= 1'b1;
                    end
                end
                c_EXEC: begin
                    if (w_is_branch) begin
                        // Branches retire straight out of EXEC.
                        r_state <= c_FETCH;
                        r_count <= r_count + c_COUNT_ONE;
                    end else if (w_is_load || w_is_store) begin
                        r_state <= c_MEM;
                    end else begin
                        r_state <= c_WB;
                    end
                end
                c_MEM: begin
                    if (dmem_ready) begin
                        if (w_is_store) begin
                            // Stores have nothing to write back.
                            r_state <= c_FETCH;
                            r_count <= r_count + c_COUNT_ONE;
                        end else begin
                            r_state <= c_WB;
                        end
                    end
                end
                c_WB: begin
                    r_state <= c_FETCH;
                    r_count <= r_count + c_COUNT_ONE;
                end
                c_TRAP: begin
                    r_state <= c_TRAP;
                end
                default: begin
                    // Unused encodings fall back into the fetch loop.
                    r_state <= c_FETCH;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Strobes: decoded from registered state plus latched opcode/rd and
    // the handshake inputs. Forced low while reset is asserted because the
    // reset state (FETCH) would otherwise raise imem_req.
    // ------------------------------------------------------------------
    always_comb begin
        imem_req  = 1'b0;
        ir_write  = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 2'b00;
        pc_write  = 1'b0;
        pc_src    = 2'b00;
        if (!reset) begin
            case (r_state)
                c_FETCH: begin
                    imem_req = 1'b1;
                    ir_write = imem_ready;
                end
                c_EXEC: begin
                    alu_src_a = w_is_auipc;
                    alu_src_b = w_is_i | w_is_load | w_is_store | w_is_auipc | w_is_jalr;
                    if (w_is_branch) begin
                        pc_write = 1'b1;
                        pc_src   = branch_taken ? 2'b01 : 2'b00;
                    end
                end
                c_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = w_is_store;
                    pc_write = w_is_store & dmem_ready;
                end
                c_WB: begin
                    reg_write = (r_rd != 5'd0);
                    pc_write  = 1'b1;
                    // JALR target is the ALU result, which needs the immediate.
                    alu_src_b = w_is_jalr;
                    if (w_is_load) begin
                        wb_sel = 2'b01;
                    end else if (w_is_jal || w_is_jalr) begin
                        wb_sel = 2'b10;
                    end else if (w_is_lui) begin
                        wb_sel = 2'b11;
                    end else begin
                        wb_sel = 2'b00;
                    end
                    if (w_is_jal) begin
                        pc_src = 2'b01;
                    end else if (w_is_jalr) begin
                        pc_src = 2'b10;
                    end else begin
                        pc_src = 2'b00;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign state       = r_state;
    assign illegal     = r_illegal;
    assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_ctrl
//  Purpose  : Scoreboard bench for multicycle_ctrl. An instruction-level model
//             expands each instruction into its expected per-cycle outputs;
//             a monitor compares them against the DUT every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    localparam int CW = 4;   // narrow counter so random runs wrap it

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4;
    localparam int K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   instruction = 32'd0;
    logic          imem_ready = 1'b0, dmem_ready = 1'b0, branch_taken = 1'b0;
    logic          imem_req, ir_write, alu_src_a, alu_src_b, dmem_req, dmem_we;
    logic          reg_write, pc_write, illegal;
    logic [1:0]    wb_sel, pc_src;
    logic [2:0]    state;
    logic [CW-1:0] instr_count;

    always #5 clk = ~clk;

    multicycle_ctrl #(.COUNT_W(CW)) dut (
        .clk(clk), .reset(reset), .instruction(instruction),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
        .imem_req(imem_req), .ir_write(ir_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .reg_write(reg_write), .wb_sel(wb_sel), .pc_write(pc_write),
        .pc_src(pc_src), .state(state), .illegal(illegal), .instr_count(instr_count)
    );

    typedef struct packed {
        logic [2:0]    st;
        logic          ireq, irw, a, b, dreq, dwe, regw;
        logic [1:0]    wbs;
        logic          pcw;
        logic [1:0]    pcs;
        logic          ill;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [CW-1:0] m_cnt   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    function automatic int kind(input logic [6:0] op);
        case (op)
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b0000011: return K_LD;
            7'b0100011: return K_ST;
            7'b1100011: return K_BR;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            7'b0110111: return K_LUI;
            7'b0010111: return K_AUIPC;
            default:    return -1;
        endcase
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic exp_t base(input logic [2:0] st);
        exp_t e;
        e     = '0;
        e.st  = st;
        e.cnt = m_cnt;
        return e;
    endfunction

    // Monitor: one expected record per clock, compared mid-cycle.
    initial begin : monitor
        exp_t e, a;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                a = '{state, imem_req, ir_write, alu_src_a, alu_src_b, dmem_req,
                      dmem_we, reg_write, wb_sel, pc_write, pc_src, illegal, instr_count};
                check("cycle_outputs", 32'(a), 32'(e));
            end
        end
    end

    // Drive one clock's inputs and queue what the DUT must show in that clock.
    task automatic cyc(input logic r, input logic ir, input logic dr, input logic bt,
                       input logic [31:0] ins, input exp_t e);
        @(posedge clk);
        #1;
        reset        = r;
        imem_ready   = ir;
        dmem_ready   = dr;
        branch_taken = bt;
        instruction  = ins;
        q.push_back(e);
    endtask

    // Expand one instruction into its cycle-by-cycle expectations.
    // iw: fetch wait cycles, dw: memory wait cycles, abort: reset mid-MEM.
    task automatic run_instr(input logic [31:0] ins, input int iw, input int dw,
                             input logic bt, input bit abort);
        exp_t       e;
        int         k;
        logic [4:0] rd;
        k  = kind(ins[6:0]);
        rd = ins[11:7];

        for (int i = 0; i < iw; i++) begin
            e = base(3'd0); e.ireq = 1'b1;
            cyc(1'b0, 1'b0, rb(), rb(), $urandom(), e);
        end
        e = base(3'd0); e.ireq = 1'b1; e.irw = 1'b1;
        cyc(1'b0, 1'b1, rb(), rb(), ins, e);

        e = base(3'd1);
        cyc(1'b0, rb(), rb(), rb(), $urandom(), e);

        if (k < 0) begin
            for (int i = 0; i < 3; i++) begin
                e = base(3'd5); e.ill = 1'b1;
                cyc(1'b0, rb(), rb(), rb(), $urandom(), e);
            end
            m_cnt = '0;
            e = base(3'd0);
            cyc(1'b1, rb(), rb(), rb(), $urandom(), e);
            return;
        end

        e = base(3'd2);
        e.a = (k == K_AUIPC);
        e.b = (k == K_I || k == K_LD || k == K_ST || k == K_AUIPC || k == K_JALR);
        if (k == K_BR) begin
            e.pcw = 1'b1;
            e.pcs = bt ? 2'b01 : 2'b00;
            cyc(1'b0, rb(), rb(), bt, $urandom(), e);
            m_cnt++;
            return;
        end
        cyc(1'b0, rb(), rb(), rb(), $urandom(), e);

        if (k == K_LD || k == K_ST) begin
            for (int i = 0; i < dw; i++) begin
                if (abort && i == 1) begin
                    @(posedge clk);
                    #1;
                    reset      = 1'b0;
                    dmem_ready = 1'b0;
                    m_cnt      = '0;
                    e          = base(3'd0);
                    q.push_back(e);
                    #1;
                    check("mid_mem_state", 32'(state), 32'd3);
                    #1;
                    reset = 1'b1;
                    #1;
                    check("async_rst_state", 32'(state), 32'd0);
                    check("async_rst_dmem_req", 32'(dmem_req), 32'd0);
                    check("async_rst_count", 32'(instr_count), 32'd0);
                    return;
                end
                e = base(3'd3); e.dreq = 1'b1; e.dwe = (k == K_ST);
                cyc(1'b0, rb(), 1'b0, rb(), $urandom(), e);
            end
            e = base(3'd3); e.dreq = 1'b1; e.dwe = (k == K_ST); e.pcw = (k == K_ST);
            cyc(1'b0, rb(), 1'b1, rb(), $urandom(), e);
            if (k == K_ST) begin
                m_cnt++;
                return;
            end
        end

        e = base(3'd4);
        e.regw = (rd != 5'd0);
        e.pcw  = 1'b1;
        e.b    = (k == K_JALR);
        e.wbs  = (k == K_LD) ? 2'b01 :
                 (k == K_JAL || k == K_JALR) ? 2'b10 :
                 (k == K_LUI) ? 2'b11 : 2'b00;
        e.pcs  = (k == K_JAL) ? 2'b01 : (k == K_JALR) ? 2'b10 : 2'b00;
        cyc(1'b0, rb(), rb(), rb(), $urandom(), e);
        m_cnt++;
    endtask

    logic [6:0] ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

    initial begin : stim
        logic [31:0] ins;
        logic [6:0]  op;
        int          sel;

        // Reset held for two cycles: everything low, count zero.
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, base(3'd0));
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0013, base(3'd0));

        // Directed instructions
        run_instr(32'h0050_0093, 0, 0, 1'b0, 1'b0);  // addi x1,x0,5
        run_instr(32'h0000_0463, 0, 0, 1'b1, 1'b0);  // beq taken
        run_instr(32'h0000_A103, 0, 3, 1'b0, 1'b0);  // lw, 3 wait cycles
        run_instr(32'h0000_006F, 1, 0, 1'b0, 1'b0);  // jal x0
        run_instr(32'h1234_52B7, 2, 0, 1'b0, 1'b0);  // lui x5
        run_instr(32'h0000_007F, 0, 0, 1'b0, 1'b0);  // illegal -> trap, reset
        run_instr(32'h0000_0093, 0, 0, 1'b0, 1'b0);  // addi with rd=1
        run_instr(32'h0000_A103, 0, 3, 1'b0, 1'b1);  // lw, reset mid-MEM
        run_instr(32'h0020_A023, 0, 2, 1'b0, 1'b0);  // sw

        // Randomised mix, long enough to wrap the counter many times
        for (int n = 0; n < 300; n++) begin
            sel = int'($urandom_range(0, 29));
            if (sel < 27) begin
                op = ops[sel % 9];
            end else begin
                op = 7'($urandom());
                while (kind(op) >= 0) op = 7'($urandom());
            end
            ins      = $urandom();
            ins[6:0] = op;
            if ($urandom_range(0, 3) == 0) ins[11:7] = 5'd0;
            run_instr(ins, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rb(), 1'b0);
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter COUNT_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port instruction  input  32  instruction word from instruction memory, sampled only in FETCH when imem_ready=1.
REQ-005 SHALL have port imem_ready  input  1  instruction memory has valid data this cycle.
REQ-006 SHALL have port dmem_ready  input  1  data memory access completes this cycle.
REQ-007 SHALL have port branch_taken  input  1  branch comparison result from ALU, valid in EXEC.
REQ-008 SHALL have port imem_req  output  1  instruction fetch request.
REQ-009 SHALL have port ir_write  output  1  load instruction register.
REQ-010 SHALL have port alu_src_a  output  1  0=rs1, 1=PC.
REQ-011 SHALL have port alu_src_b  output  1  0=rs2, 1=immediate.
REQ-012 SHALL have port dmem_req, dmem_we  output  1 each  data access request / write enable.
REQ-013 SHALL have port reg_write  output  1  register-file write strobe.
REQ-014 SHALL have port wb_sel  output  2  00=ALU, 01=load data, 10=PC+4, 11=immediate.
REQ-015 SHALL have port pc_write, pc_src  output  1, 2  PC update strobe; pc_src 00=PC+4, 01=PC+imm, 10=ALU result (JALR, bit0 cleared downstream).
REQ-016 SHALL have ports state  output  3, illegal  output  1, instr_count  output  COUNT_W.

Function
REQ-017 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6-7 unreachable, recover to FETCH next cycle.
REQ-018 SHALL derive all strobes combinationally from registered state and latched opcode/rd; no combinational path from instruction to any output.
REQ-019 FETCH: imem_req=1; stay while imem_ready=0; on imem_ready=1 assert ir_write, latch opcode[6:0] and rd[11:7], go DECODE.
REQ-020 DECODE: one cycle; legal opcodes 0110011,0010011,0000011,0100011,1100011,1101111,1100111,0110111,0010111 -> EXEC; any other -> TRAP.
REQ-021 EXEC R/I/LUI/AUIPC/JAL/JALR -> WB; load/store -> MEM (alu_src_b=1); branch -> FETCH with pc_write=1, pc_src=01 if branch_taken else 00, instr_count +1.
REQ-022 EXEC operand selects: R/branch alu_src_b=0; AUIPC alu_src_a=1, alu_src_b=1; JALR alu_src_b=1; all others alu_src_a=0.
REQ-023 MEM: dmem_req=1, dmem_we=1 for store only; hold while dmem_ready=0; on dmem_ready store -> FETCH with pc_write=1, pc_src=00, count +1; load -> WB.
REQ-024 WB: reg_write=1 unless latched rd=0; pc_write=1; count +1; -> FETCH.
REQ-025 WB selects: R/I/AUIPC wb_sel=00; load 01; JAL/JALR 10; LUI 11; pc_src JAL=01, JALR=10, others 00; JALR keeps alu_src_b=1 in WB.
REQ-026 Strobes not listed for a state SHALL be 0; wb_sel and pc_src SHALL be 00 when unused.
REQ-027 TRAP: illegal=1 (sticky), all strobes 0, state held until reset.
REQ-028 instr_count SHALL wrap from all-ones to 0; exactly one increment per retired instruction, none on illegal instruction.
REQ-029 Each instruction retires with exactly one pc_write pulse; CPI: ALU/JAL/JALR 4, branch 3, store 4, load 5, plus memory wait cycles.

Reset
REQ-030 reset=1 SHALL immediately force state=FETCH, illegal=0, instr_count=0, latched opcode/rd=0, and all strobes 0 while reset is high, including mid-FETCH or mid-MEM.
REQ-031 First imem_req SHALL assert in the first cycle after reset deasserts.

Verification
REQ-032 addi x1,x0,5 (0x00500093), imem_ready=1 -> states 0,1,2,4; WB: reg_write=1, wb_sel=00, pc_write=1, pc_src=00; instr_count=1.
REQ-033 beq taken (0x00000463), branch_taken=1 -> EXEC pc_write=1, pc_src=01, no reg_write, back in FETCH after 3 cycles.
REQ-034 lw (0x0000A103), dmem_ready low 3 cycles -> MEM held 4 cycles with dmem_req=1, dmem_we=0; then WB wb_sel=01, reg_write=1.
REQ-035 jal x0 (0x0000006F) -> WB reg_write=0 (rd=0), pc_src=01, pc_write=1; lui x5 (0x123452B7) -> WB wb_sel=11.
REQ-036 opcode 0x7F -> TRAP after DECODE, illegal=1, count unchanged; reset pulse mid-MEM -> state=0, strobes 0, count=0 asynchronously.
